decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised instruction decode stage for the 16-bit CPU datapath, between instruction fetch and the register file/ALU. It accepts one 16-bit instruction per cycle over a valid/ready handshake and holds it in a two-entry skid buffer. It emits the decoded fields from registers, with one cycle of latency:

- opcode
- register indices
- one-hot write enable
- extended immediate
- immediate select
- load/store/illegal flags

Unlike the combinational field splitter, it adds backpressure, flush, immediate extension and illegal-instruction detection.

## Interface
Parameters:
- DATA_WIDTH, 16, datapath width; must be ≥ 16.
- NUM_REGS, 16, number of architectural registers; must be a power of 2 and ≤ 16.

Ports:
- clk  in  1  system clock; everything samples on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_in  in  16  instruction word.
  - Fields: op = [15:12], Rdest = [11:8], ext = [7:4], Rsrc = [3:0], imm8 = [7:0].
- instr_valid  in  1  instr_in is valid.
- instr_ready  out  1  decode can accept an instruction.
- flush  in  1  discard all buffered instructions.
- out_valid  out  1  the decoded outputs are valid.
- out_ready  in  1  downstream consumes the decoded outputs.
- opcode  out  8  {op, ext}.
- Rdest  out  $clog2(NUM_REGS)  destination register index.
- Rsrc  out  $clog2(NUM_REGS)  source register index.
- wEnable  out  NUM_REGS  one-hot register write enable.
- Imm_out  out  DATA_WIDTH  extended immediate.
- Imm_select  out  1  1 selects Imm_out as the B operand instead of Rsrc.
- illegal, is_load, is_store  out  1 each  decode flags.

## Operation
Storage:
- Two entries: a main output register and a skid register, each holding raw instr + valid.
- Decode is combinational from the main register. All outputs are driven from stored state only; there is no combinational path from instr_in to the outputs.

Handshake:
- Input transfer occurs when instr_valid & instr_ready.
- Output transfer occurs when out_valid & out_ready.
- instr_ready = !skid_valid. This is a registered signal, with no combinational dependence on out_ready.
- Accept with main empty, or with main consumed in the same cycle: the instruction goes to main.
- Accept with main held (out_valid & !out_ready): the instruction goes to skid.
- Main consumed while skid is full: skid moves to main, and skid is cleared.
- Order is strictly preserved.

Decode rules:
- Register instructions, op = 0000, with ext:
  - ADD 0101, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011, MOV 1101.
  - Imm_select = 0.
- Shift, op = 1000: ext = 0100 is LSH (register); ext = 000x is LSHI.
- Immediate instructions: ADDI 0101, SUBI 1001, CMPI 1011, MOVI 1101 sign-extend imm8; ANDI 0001, ORI 0010, XORI 0011 zero-extend imm8.
- LUI, op = 1111: Imm_out = zero-extended {imm8, 8'h00}.
- LSHI: Imm_out = sign-extended {instr[3:0]}, i.e. a signed shift amount. Imm_select = 1 for all immediate forms.
- op = 0100:
  - ext = 0000 is LOAD (is_load = 1, writes Rdest).
  - ext = 0100 is STOR (is_store = 1, no write).
  - ext = 1000 is JAL (writes Rdest).
  - ext = 1100 is Jcond (no write).
- op = 1100: Bcond, Imm_out = sign-extended imm8, no write.
- Register write: wEnable = 1 << Rdest for writing instructions. CMP, CMPI, STOR, Bcond, Jcond and illegal instructions give wEnable = 0.
- Illegal: any unlisted op/ext, or Rdest/Rsrc ≥ NUM_REGS (instr[11:8] or [3:0] out of range). On illegal, assert illegal = 1 and force wEnable = 0, is_load = 0, is_store = 0. The instruction still flows through the handshake.
- Rdest and Rsrc are the low $clog2(NUM_REGS) bits of their fields.

## Timing
- Reset (async assert, sync release): both entries invalid.
  - instr_ready = 1, out_valid = 0.
  - opcode = 0, Rdest = 0, Rsrc = 0, wEnable = 0, Imm_out = 0, Imm_select = 0, illegal = 0, is_load = 0, is_store = 0.
  - Decode outputs read 0 whenever main is empty.
- Latency: an instruction accepted at edge N is visible with out_valid at edge N (+1 cycle from its presentation).
- Throughput: 1 instruction per cycle while out_ready stays high.
- Full: with both entries valid, instr_ready = 0 and new input is ignored.
- flush:
  - At the next edge, both entries are cleared and out_valid = 0.
  - An input presented in the flush cycle is dropped, even if instr_ready = 1.
  - A simultaneous output transfer still counts as consumed.
- Reset mid-stream drops all buffered instructions immediately.

## Structure
- Shared package cpu_pkg holds:
  - op/ext constants: OP_REG, OP_LOAD_STORE, OP_SHIFT, OP_BCOND, OP_LUI, EXT_ADD…EXT_JCOND.
  - decoded_t struct: opcode, Rdest, Rsrc, Imm, flags.
- The top file holds the skid control.
- Sub-module instr_field_decode is purely combinational: instr + parameters → decoded_t. It is also reused by the future fetch-side branch predictor.

## Test plan
1. **Reset state.** Reset low mid-stream → all outputs 0, instr_ready = 1.
2. **ADDI immediate.** ADDI r3, -2 (0x53FE), out_ready = 1 → next cycle:
   - out_valid = 1, opcode = 0x5F, Rdest = 3.
   - wEnable = 0x0008, Imm_out = 0xFFFE, Imm_select = 1.
3. **Backpressure.** Hold out_ready = 0 and stream 0x0152 (ADD r1, r2), 0x0213, 0x0314:
   - The first two are accepted, the third sees instr_ready = 0.
   - Releasing out_ready delivers them in order, 1 per cycle, with no loss or duplication.
4. **Store and compare.** STOR 0x4142 → is_store = 1, wEnable = 0. CMP 0x01B2 → wEnable = 0, illegal = 0.
5. **Reduced register count.** NUM_REGS = 8, MOV r9, r1 (0x09D1) → illegal = 1, wEnable = 0. Undefined ext (0x0071) → illegal = 1.
6. **Flush.** flush with both entries full while presenting 0xF1AB (LUI) → next cycle out_valid = 0 and LUI is not delivered. Re-present LUI → Imm_out = 0xAB00, Rdest = 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared ISA constants and decoded-instruction types for the 16-bit CPU datapath.
// Used by the decode stage and by any other consumer of instr_field_decode.
package cpu_pkg;

  localparam logic [3:0] OP_REG        = 4'b0000;
  localparam logic [3:0] OP_ANDI       = 4'b0001;
  localparam logic [3:0] OP_ORI        = 4'b0010;
  localparam logic [3:0] OP_XORI       = 4'b0011;
  localparam logic [3:0] OP_LOAD_STORE = 4'b0100;
  localparam logic [3:0] OP_ADDI       = 4'b0101;
  localparam logic [3:0] OP_SHIFT      = 4'b1000;
  localparam logic [3:0] OP_SUBI       = 4'b1001;
  localparam logic [3:0] OP_CMPI       = 4'b1011;
  localparam logic [3:0] OP_BCOND      = 4'b1100;
  localparam logic [3:0] OP_MOVI       = 4'b1101;
  localparam logic [3:0] OP_LUI        = 4'b1111;

  localparam logic [3:0] EXT_AND   = 4'b0001;
  localparam logic [3:0] EXT_OR    = 4'b0010;
  localparam logic [3:0] EXT_XOR   = 4'b0011;
  localparam logic [3:0] EXT_ADD   = 4'b0101;
  localparam logic [3:0] EXT_SUB   = 4'b1001;
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_MOV   = 4'b1101;
  localparam logic [3:0] EXT_LSH   = 4'b0100;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  typedef struct packed {
    logic imm_sel;
    logic imm_sext;
    logic write;
    logic is_load;
    logic is_store;
    logic illegal;
  } decode_flags_t;

  // imm is the 16-bit extended value; imm_sext tells wider datapaths how to extend it further.
  typedef struct packed {
    logic [7:0]    opcode;
    logic [3:0]    rdest;
    logic [3:0]    rsrc;
    logic [15:0]   imm;
    decode_flags_t flags;
  } decoded_t;

  function automatic logic is_alu_ext(input logic [3:0] ext);
    return ext inside {EXT_ADD, EXT_SUB, EXT_CMP, EXT_AND, EXT_OR, EXT_XOR, EXT_MOV};
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational instruction decoder: raw 16-bit word to decoded_t.
// Rsrc range is only checked where [3:0] names a register rather than immediate bits.
module instr_field_decode
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [15:0] instr,
  output decoded_t    dec
);

  logic [3:0] op, ext, rd, rs;
  logic [7:0] imm8;
  logic       legal, uses_rsrc;

  assign op   = instr[15:12];
  assign rd   = instr[11:8];
  assign ext  = instr[7:4];
  assign rs   = instr[3:0];
  assign imm8 = instr[7:0];

  always_comb begin
    dec        = '0;
    legal      = 1'b1;
    uses_rsrc  = 1'b0;
    dec.opcode = {op, ext};
    dec.rdest  = rd;
    dec.rsrc   = rs;
    case (op)
      OP_REG: begin
        uses_rsrc       = 1'b1;
        legal           = is_alu_ext(ext);
        dec.flags.write = (ext != EXT_CMP);
      end
      OP_SHIFT: begin
        if (ext == EXT_LSH) begin
          uses_rsrc       = 1'b1;
          dec.flags.write = 1'b1;
        end else if (ext[3:1] == 3'b000) begin
          dec.imm            = {{12{rs[3]}}, rs};
          dec.flags.imm_sel  = 1'b1;
          dec.flags.imm_sext = 1'b1;
          dec.flags.write    = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI: begin
        dec.imm            = {{8{imm8[7]}}, imm8};
        dec.flags.imm_sel  = 1'b1;
        dec.flags.imm_sext = 1'b1;
        dec.flags.write    = (op != OP_CMPI);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec.imm           = {8'h00, imm8};
        dec.flags.imm_sel = 1'b1;
        dec.flags.write   = 1'b1;
      end
      OP_LUI: begin
        dec.imm           = {imm8, 8'h00};
        dec.flags.imm_sel = 1'b1;
        dec.flags.write   = 1'b1;
      end
      OP_LOAD_STORE: begin
        uses_rsrc = 1'b1;
        case (ext)
          EXT_LOAD: begin
            dec.flags.is_load = 1'b1;
            dec.flags.write   = 1'b1;
          end
          EXT_STOR:  dec.flags.is_store = 1'b1;
          EXT_JAL:   dec.flags.write    = 1'b1;
          EXT_JCOND: ;
          default:   legal = 1'b0;
        endcase
      end
      OP_BCOND: begin
        dec.imm            = {{8{imm8[7]}}, imm8};
        dec.flags.imm_sel  = 1'b1;
        dec.flags.imm_sext = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (({1'b0, rd} >= 5'(NUM_REGS)) || (uses_rsrc && ({1'b0, rs} >= 5'(NUM_REGS))))
      legal = 1'b0;
    if (!legal) begin
      dec.imm           = '0;
      dec.flags         = '0;
      dec.flags.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: two-entry skid buffer (main + skid) feeding a combinational
// decode of the main entry. instr_ready depends only on registered skid state.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [15:0]                  instr_in,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   opcode,
  output logic [$clog2(NUM_REGS)-1:0]  Rdest,
  output logic [$clog2(NUM_REGS)-1:0]  Rsrc,
  output logic [NUM_REGS-1:0]          wEnable,
  output logic [DATA_WIDTH-1:0]        Imm_out,
  output logic                         Imm_select,
  output logic                         illegal,
  output logic                         is_load,
  output logic                         is_store
);

  localparam int RW = $clog2(NUM_REGS);

  logic [15:0] main_instr, skid_instr;
  logic        main_valid, skid_valid;
  logic        in_fire, out_fire, main_free;
  decoded_t    dec;

  assign instr_ready = !skid_valid;
  assign in_fire     = instr_valid && !skid_valid && !flush;
  assign out_fire    = main_valid && out_ready;
  assign main_free   = !main_valid || out_fire;
  assign out_valid   = main_valid;

  // skid only ever fills while main is held, so skid_valid implies main_valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_instr <= '0;
      skid_instr <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_instr <= skid_instr;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= in_fire;
        if (in_fire) main_instr <= instr_in;
      end
    end else if (in_fire) begin
      skid_instr <= instr_in;
      skid_valid <= 1'b1;
    end
  end

  instr_field_decode #(.NUM_REGS(NUM_REGS)) u_field_decode (
    .instr (main_instr),
    .dec   (dec)
  );

  always_comb begin
    opcode     = '0;
    Rdest      = '0;
    Rsrc       = '0;
    wEnable    = '0;
    Imm_out    = '0;
    Imm_select = 1'b0;
    illegal    = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    if (main_valid) begin
      opcode     = dec.opcode;
      Rdest      = dec.rdest[RW-1:0];
      Rsrc       = dec.rsrc[RW-1:0];
      wEnable    = dec.flags.write ? (NUM_REGS'(1) << Rdest) : '0;
      Imm_out    = dec.flags.imm_sext ? DATA_WIDTH'($signed(dec.imm)) : DATA_WIDTH'(dec.imm);
      Imm_select = dec.flags.imm_sel;
      illegal    = dec.flags.illegal;
      is_load    = dec.flags.is_load;
      is_store   = dec.flags.is_store;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector tables, hand sequences for backpressure,
// flush and reset, then a randomized stream checked against a queue-based model.
module tb_decode_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 16-register instance
  logic [15:0] instr_in;
  logic        instr_valid, flush, out_ready;
  logic        instr_ready, out_valid;
  logic [7:0]  opcode;
  logic [3:0]  Rdest, Rsrc;
  logic [15:0] wEnable, Imm_out;
  logic        Imm_select, illegal, is_load, is_store;

  // 8-register instance
  logic [15:0] i8_instr;
  logic        i8_valid, i8_flush, i8_out_ready;
  logic        o8_ready, o8_valid;
  logic [7:0]  o8_opcode;
  logic [2:0]  o8_rdest, o8_rsrc;
  logic [7:0]  o8_wen;
  logic [15:0] o8_imm;
  logic        o8_sel, o8_ill, o8_ld, o8_st;

  decode_stage #(.DATA_WIDTH(16), .NUM_REGS(16)) u_dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .Rdest(Rdest), .Rsrc(Rsrc), .wEnable(wEnable), .Imm_out(Imm_out),
    .Imm_select(Imm_select), .illegal(illegal), .is_load(is_load), .is_store(is_store)
  );

  decode_stage #(.DATA_WIDTH(16), .NUM_REGS(8)) u_dut8 (
    .clk(clk), .reset(reset), .instr_in(i8_instr), .instr_valid(i8_valid),
    .instr_ready(o8_ready), .flush(i8_flush), .out_valid(o8_valid), .out_ready(i8_out_ready),
    .opcode(o8_opcode), .Rdest(o8_rdest), .Rsrc(o8_rsrc), .wEnable(o8_wen), .Imm_out(o8_imm),
    .Imm_select(o8_sel), .illegal(o8_ill), .is_load(o8_ld), .is_store(o8_st)
  );

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  opc;
    logic [3:0]  rd, rs;
    logic [15:0] wen, imm;
    logic        sel, ill, ld, st;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_fields16(input string tag, input vec_t e);
    chk({tag, ".opcode"}, opcode, e.opc);
    chk({tag, ".Rdest"}, Rdest, e.rd);
    chk({tag, ".Rsrc"}, Rsrc, e.rs);
    chk({tag, ".wEnable"}, wEnable, e.wen);
    chk({tag, ".Imm_out"}, Imm_out, e.imm);
    chk({tag, ".Imm_select"}, Imm_select, e.sel);
    chk({tag, ".illegal"}, illegal, e.ill);
    chk({tag, ".is_load"}, is_load, e.ld);
    chk({tag, ".is_store"}, is_store, e.st);
  endtask

  task automatic chk_zero16(input string tag);
    chk({tag, ".out_valid"}, out_valid, 1'b0);
    chk({tag, ".decode_bits"},
        {opcode, Rdest, Rsrc, wEnable, Imm_out, Imm_select, illegal, is_load, is_store}, '0);
  endtask

  // Reference decode from the ISA rules (16 architectural registers)
  function automatic vec_t model(input logic [15:0] i);
    vec_t e;
    int op, ext, sx8, sx4;
    bit legal, wr, sel, ld, st;
    int imm;
    op = int'(i[15:12]); ext = int'(i[7:4]);
    sx8 = int'($signed(i[7:0]));
    sx4 = int'($signed(i[3:0]));
    legal = 1; wr = 0; sel = 0; ld = 0; st = 0; imm = 0;
    if (op == 0) begin
      legal = (ext inside {1, 2, 3, 5, 9, 11, 13});
      wr = (ext != 11);
    end else if (op inside {1, 2, 3}) begin
      sel = 1; imm = int'(i[7:0]); wr = 1;
    end else if (op inside {5, 9, 11, 13}) begin
      sel = 1; imm = sx8; wr = (op != 11);
    end else if (op == 15) begin
      sel = 1; imm = int'(i[7:0]) * 256; wr = 1;
    end else if (op == 12) begin
      sel = 1; imm = sx8;
    end else if (op == 8) begin
      if (ext == 4) wr = 1;
      else if (ext < 2) begin sel = 1; imm = sx4; wr = 1; end
      else legal = 0;
    end else if (op == 4) begin
      if (ext == 0) begin ld = 1; wr = 1; end
      else if (ext == 4) st = 1;
      else if (ext == 8) wr = 1;
      else if (ext != 12) legal = 0;
    end else begin
      legal = 0;
    end
    if (!legal) begin wr = 0; sel = 0; imm = 0; ld = 0; st = 0; end
    e.instr = i;
    e.opc   = {i[15:12], i[7:4]};
    e.rd    = i[11:8];
    e.rs    = i[3:0];
    e.wen   = wr ? 16'(1 << int'(i[11:8])) : 16'h0;
    e.imm   = 16'(imm);
    e.sel   = sel; e.ill = !legal; e.ld = ld; e.st = st;
    return e;
  endfunction

  task automatic idle_inputs();
    instr_valid = 0; flush = 0; out_ready = 0; instr_in = '0;
    i8_valid = 0; i8_flush = 0; i8_out_ready = 0; i8_instr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  vec_t vecs[$];
  vec_t vecs8[$];
  vec_t q[$];

  initial begin
    // instr, opcode, rd, rs, wen, imm, sel, ill, ld, st
    vecs.push_back('{16'h53FE, 8'h5F, 4'h3, 4'hE, 16'h0008, 16'hFFFE, 1, 0, 0, 0}); // ADDI r3,-2
    vecs.push_back('{16'h0152, 8'h05, 4'h1, 4'h2, 16'h0002, 16'h0000, 0, 0, 0, 0}); // ADD
    vecs.push_back('{16'h4142, 8'h44, 4'h1, 4'h2, 16'h0000, 16'h0000, 0, 0, 0, 1}); // STOR
    vecs.push_back('{16'h01B2, 8'h0B, 4'h1, 4'h2, 16'h0000, 16'h0000, 0, 0, 0, 0}); // CMP
    vecs.push_back('{16'hF1AB, 8'hFA, 4'h1, 4'hB, 16'h0002, 16'hAB00, 1, 0, 0, 0}); // LUI
    vecs.push_back('{16'h12F0, 8'h1F, 4'h2, 4'h0, 16'h0004, 16'h00F0, 1, 0, 0, 0}); // ANDI
    vecs.push_back('{16'h4503, 8'h40, 4'h5, 4'h3, 16'h0020, 16'h0000, 0, 0, 1, 0}); // LOAD
    vecs.push_back('{16'hC2F8, 8'hCF, 4'h2, 4'h8, 16'h0000, 16'hFFF8, 1, 0, 0, 0}); // Bcond
    vecs.push_back('{16'h8A0E, 8'h80, 4'hA, 4'hE, 16'h0400, 16'hFFFE, 1, 0, 0, 0}); // LSHI -2
    vecs.push_back('{16'h8317, 8'h81, 4'h3, 4'h7, 16'h0008, 16'h0007, 1, 0, 0, 0}); // LSHI +7
    vecs.push_back('{16'h8743, 8'h84, 4'h7, 4'h3, 16'h0080, 16'h0000, 0, 0, 0, 0}); // LSH
    vecs.push_back('{16'h4F82, 8'h48, 4'hF, 4'h2, 16'h8000, 16'h0000, 0, 0, 0, 0}); // JAL r15
    vecs.push_back('{16'h41C5, 8'h4C, 4'h1, 4'h5, 16'h0000, 16'h0000, 0, 0, 0, 0}); // Jcond
    vecs.push_back('{16'h6123, 8'h62, 4'h1, 4'h3, 16'h0000, 16'h0000, 0, 1, 0, 0}); // bad op
    vecs.push_back('{16'h4015, 8'h41, 4'h0, 4'h5, 16'h0000, 16'h0000, 0, 1, 0, 0}); // bad ld/st ext
    vecs.push_back('{16'h8323, 8'h82, 4'h3, 4'h3, 16'h0000, 16'h0000, 0, 1, 0, 0}); // bad shift ext
    vecs.push_back('{16'hD07F, 8'hD7, 4'h0, 4'hF, 16'h0001, 16'h007F, 1, 0, 0, 0}); // MOVI r0
    vecs.push_back('{16'h3E80, 8'h38, 4'hE, 4'h0, 16'h4000, 16'h0080, 1, 0, 0, 0}); // XORI zext

    vecs8.push_back('{16'h09D1, 8'h0D, 4'h1, 4'h1, 16'h0000, 16'h0000, 0, 1, 0, 0}); // MOV r9
    vecs8.push_back('{16'h0071, 8'h07, 4'h0, 4'h1, 16'h0000, 16'h0000, 0, 1, 0, 0}); // bad ext
    vecs8.push_back('{16'h07D6, 8'h0D, 4'h7, 4'h6, 16'h0080, 16'h0000, 0, 0, 0, 0}); // MOV r7,r6
    vecs8.push_back('{16'h0159, 8'h05, 4'h1, 4'h1, 16'h0000, 16'h0000, 0, 1, 0, 0}); // ADD rs=9
    vecs8.push_back('{16'h4702, 8'h40, 4'h7, 4'h2, 16'h0080, 16'h0000, 0, 0, 1, 0}); // LOAD r7

    idle_inputs();
    reset = 0;
    #1;
    chk("reset.instr_ready", instr_ready, 1'b1);
    chk_zero16("reset");
    @(negedge clk);
    reset = 1;

    // Table: one instruction per cycle, out_ready held high
    out_ready = 1;
    foreach (vecs[k]) begin
      instr_in = vecs[k].instr; instr_valid = 1;
      @(negedge clk);
      chk($sformatf("vec%0d.out_valid", k), out_valid, 1'b1);
      chk_fields16($sformatf("vec%0d", k), vecs[k]);
    end
    instr_valid = 0;
    @(negedge clk);
    chk("drain.out_valid", out_valid, 1'b0);

    i8_out_ready = 1;
    foreach (vecs8[k]) begin
      i8_instr = vecs8[k].instr; i8_valid = 1;
      @(negedge clk);
      chk($sformatf("r8_%0d.out_valid", k), o8_valid, 1'b1);
      chk($sformatf("r8_%0d.opcode", k), o8_opcode, vecs8[k].opc);
      chk($sformatf("r8_%0d.Rdest", k), o8_rdest, vecs8[k].rd[2:0]);
      chk($sformatf("r8_%0d.Rsrc", k), o8_rsrc, vecs8[k].rs[2:0]);
      chk($sformatf("r8_%0d.wEnable", k), o8_wen, vecs8[k].wen[7:0]);
      chk($sformatf("r8_%0d.illegal", k), o8_ill, vecs8[k].ill);
      chk($sformatf("r8_%0d.is_load", k), o8_ld, vecs8[k].ld);
      chk($sformatf("r8_%0d.is_store", k), o8_st, vecs8[k].st);
    end
    i8_valid = 0;

    // Backpressure: third instruction must be refused, first two delivered in order
    out_ready = 0;
    @(negedge clk);
    instr_in = 16'h0152; instr_valid = 1;
    @(negedge clk);
    chk("bp.ready_after_1", instr_ready, 1'b1);
    instr_in = 16'h0213;
    @(negedge clk);
    chk("bp.ready_full", instr_ready, 1'b0);
    chk("bp.head_opcode", opcode, 8'h05);
    instr_in = 16'h0314;
    @(negedge clk);
    chk("bp.still_full", instr_ready, 1'b0);
    chk("bp.head_held", opcode, 8'h05);
    chk("bp.head_rdest", Rdest, 4'h1);
    instr_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("bp.second_valid", out_valid, 1'b1);
    chk("bp.second_opcode", opcode, 8'h01);
    chk("bp.second_rdest", Rdest, 4'h2);
    chk("bp.second_rsrc", Rsrc, 4'h3);
    chk("bp.ready_again", instr_ready, 1'b1);
    @(negedge clk);
    chk_zero16("bp.empty");

    // Flush with both entries full while LUI is presented
    out_ready = 0;
    instr_in = 16'h0152; instr_valid = 1;
    @(negedge clk);
    instr_in = 16'h0213;
    @(negedge clk);
    chk("fl.full", instr_ready, 1'b0);
    instr_in = 16'hF1AB; flush = 1;
    @(negedge clk);
    flush = 0; instr_valid = 0;
    chk_zero16("fl.cleared");
    chk("fl.ready", instr_ready, 1'b1);
    // Flush with room: the presented instruction is still dropped
    instr_in = 16'h0152; instr_valid = 1;
    @(negedge clk);
    instr_in = 16'hF1AB; flush = 1;
    @(negedge clk);
    flush = 0; instr_valid = 0;
    chk_zero16("fl.dropped");
    @(negedge clk);
    chk_zero16("fl.nothing_late");
    out_ready = 1; instr_in = 16'hF1AB; instr_valid = 1;
    @(negedge clk);
    instr_valid = 0;
    chk("lui.out_valid", out_valid, 1'b1);
    chk("lui.Imm_out", Imm_out, 16'hAB00);
    chk("lui.Rdest", Rdest, 4'h1);
    @(negedge clk);

    // Reset mid-stream drops both entries immediately
    out_ready = 0; instr_in = 16'h53FE; instr_valid = 1;
    @(negedge clk);
    instr_in = 16'h0152;
    @(negedge clk);
    instr_valid = 0;
    #2 reset = 0;
    #1;
    chk("rst_mid.instr_ready", instr_ready, 1'b1);
    chk_zero16("rst_mid");
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk_zero16("rst_mid.after_release");

    // Randomized stream against a queue model
    do_reset();
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      bit in_fire, out_fire;
      @(negedge clk);
      chk("rnd.out_valid", out_valid, q.size() > 0);
      chk("rnd.instr_ready", instr_ready, q.size() < 2);
      if (q.size() > 0) chk_fields16("rnd", q[0]);
      else chk_zero16("rnd.idle");
      instr_valid = ($urandom_range(0, 3) != 0);
      instr_in    = 16'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 31) == 0);
      in_fire  = instr_valid && (q.size() < 2) && !flush;
      out_fire = (q.size() > 0) && out_ready;
      if (flush) q.delete();
      else begin
        if (out_fire) void'(q.pop_front());
        if (in_fire) q.push_back(model(instr_in));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
